// File: rtl/tt_um_serial_add_ctrl.sv
// Bit-serial adder: one full adder walks A and B LSB first, with start/ack handshake.
// Define SADD_SUB_EN to build the optional A-B mode selected by uio_in[2] at start.
module tt_um_serial_add_ctrl #(
  parameter int unsigned NBITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q;
  logic             start_q;
  logic [NBITS-1:0] a_sr_q, b_sr_q, work_q;
  logic             cy_q;
  logic [1:0]       idx_q;
  logic [3:0]       sum_q, count_q;
  logic             carry_q, busy_q, done_q, zero_q;

  logic start_edge, ack, last_bit;
  assign start_edge = uio_in[0] & ~start_q;
  assign ack        = uio_in[1];
  assign last_bit   = (idx_q == 2'(NBITS - 1));

  logic [NBITS-1:0] op_a, op_b, op_b_eff;
  logic             cy_init;
  assign op_a = ui_in[4 +: NBITS];
  assign op_b = ui_in[0 +: NBITS];

`ifdef SADD_SUB_EN
  // Two's-complement subtract: invert B and seed the carry with 1.
  assign op_b_eff = uio_in[2] ? ~op_b : op_b;
  assign cy_init  = uio_in[2];
`else
  assign op_b_eff = op_b;
  assign cy_init  = 1'b0;
`endif

  // Bits of the inputs not consumed in every configuration.
  logic unused_in;
  assign unused_in = ^{ui_in, uio_in};

  logic             s1, c1, c2, sum_bit, cy_next;
  logic [NBITS-1:0] work_next;
  always_comb begin
    s1        = a_sr_q[0] ^ b_sr_q[0];
    c1        = a_sr_q[0] & b_sr_q[0];
    sum_bit   = s1 ^ cy_q;
    c2        = s1 & cy_q;
    cy_next   = c1 | c2;
    work_next = work_q >> 1;
    work_next[NBITS-1] = sum_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      start_q <= 1'b1;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      work_q  <= '0;
      cy_q    <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else if (ena) begin
      start_q <= uio_in[0];
      case (state_q)
        StIdle: begin
          if (start_edge) begin
            a_sr_q  <= op_a;
            b_sr_q  <= op_b_eff;
            work_q  <= '0;
            cy_q    <= cy_init;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          work_q <= work_next;
          cy_q   <= cy_next;
          idx_q  <= idx_q + 2'd1;
          if (last_bit) begin
            sum_q   <= 4'(work_next);
            carry_q <= cy_next;
            zero_q  <= (work_next == '0);
            count_q <= count_q + 4'd1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (start_edge) begin
            a_sr_q  <= op_a;
            b_sr_q  <= op_b_eff;
            work_q  <= '0;
            cy_q    <= cy_init;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            state_q <= StAdd;
          end else if (ack) begin
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uo_out  = {zero_q, done_q, busy_q, carry_q, sum_q};
  assign uio_out = {count_q, 4'b0000};
  assign uio_oe  = 8'b1111_0000;

endmodule

// File: tb/tb_tt_um_serial_add_ctrl.sv
// Scoreboard bench for tt_um_serial_add_ctrl: driver pushes arithmetic expectations,
// a negedge monitor pops them whenever done rises.
module tb_tt_um_serial_add_ctrl;

  localparam int unsigned NBITS = 4;
  localparam int          M     = 1 << NBITS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_serial_add_ctrl #(.NBITS(NBITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] sum;
    logic       carry;
    logic [3:0] count;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares completions against the scoreboard and checks holds every cycle.
  initial begin : monitor
    logic       done_prev;
    logic [3:0] last_sum;
    logic       last_carry;
    exp_t       e;
    done_prev  = 1'b0;
    last_sum   = '0;
    last_carry = 1'b0;
    forever begin
      @(negedge clk);
      chk("uio_oe", uio_oe, 8'hF0);
      if (!rst_n) begin
        chk("reset_uo_out", uo_out, 0);
        chk("reset_uio_out", uio_out, 0);
        done_prev  = 1'b0;
        last_sum   = '0;
        last_carry = 1'b0;
      end else begin
        if (uo_out[6] && !done_prev) begin
          chk("done_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sum", uo_out[3:0], e.sum);
            chk("carry", uo_out[4], e.carry);
            chk("zero", uo_out[7], e.sum == 4'd0);
            chk("busy_at_done", uo_out[5], 0);
            chk("count", uio_out[7:4], e.count);
            chk("latency", cyc, e.cyc);
            last_sum   = e.sum;
            last_carry = e.carry;
          end
        end
        chk("sum_hold", uo_out[3:0], last_sum);
        chk("carry_hold", uo_out[4], last_carry);
        chk("uio_low", uio_out[3:0], 0);
        if (!uo_out[6]) chk("zero_without_done", uo_out[7], 0);
        done_prev = uo_out[6];
      end
    end
  end

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic sub,
                        input int gap, input bit mid_start, input int hold,
                        input bit with_ack);
    exp_t       e;
    int         ai, bi, s;
    bit         do_sub;
    logic [7:0] snap;
    ai = int'(a) % M;
    bi = int'(b) % M;
`ifdef SADD_SUB_EN
    do_sub = sub;
`else
    do_sub = 1'b0;
`endif
    if (do_sub) begin
      e.sum   = 4'((ai - bi + M) % M);
      e.carry = (ai >= bi);
    end else begin
      s       = ai + bi;
      e.sum   = 4'(s % M);
      e.carry = (s >= M);
    end
    model_count = (model_count + 1) % 16;
    e.count = 4'(model_count);
    e.cyc   = cyc + 1 + NBITS + gap;
    exp_q.push_back(e);
    ui_in  = {a, b};
    uio_in = {5'($urandom), sub, with_ack, 1'b1};
    step();
    chk("busy_rise", uo_out[5], 1);
    uio_in[1] = 1'b0;
    if (hold <= 1) uio_in[0] = 1'b0;
    ui_in = 8'($urandom);
    step();
    if (gap > 0) begin
      ena  = 1'b0;
      snap = uo_out;
      repeat (gap) begin
        step();
        chk("ena_hold", uo_out, snap);
      end
      ena = 1'b1;
    end
    if (mid_start && hold <= 1) begin
      uio_in[0] = 1'b1;
      step();
      uio_in[0] = 1'b0;
    end
    if (hold > 2) begin
      repeat (hold - 2) step();
      uio_in[0] = 1'b0;
    end
    for (int i = 0; i < NBITS + gap + 20 && exp_q.size() != 0; i++) step();
    chk("done_timeout", exp_q.size(), 0);
    if ($urandom_range(0, 1) == 1) begin
      uio_in[1] = 1'b1;
      step();
      uio_in[1] = 1'b0;
      chk("ack_clears_done", uo_out[6], 0);
    end
    step();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : driver
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state_uo", uo_out, 0);
    chk("reset_state_uio", uio_out, 0);
    rst_n = 1'b1;
    // Start held high through reset release must not trigger.
    repeat (5) step();
    chk("start_through_reset_busy", uo_out[5], 0);
    chk("start_through_reset_done", uo_out[6], 0);
    uio_in = 8'h00;
    step();

    run_op(4'd3, 4'd5, 1'b0, 0, 1'b0, 1, 1'b0);
    run_op(4'd15, 4'd1, 1'b0, 0, 1'b0, 1, 1'b0);
    uio_in[1] = 1'b1;
    step();
    uio_in[1] = 1'b0;
    chk("ack_done", uo_out[6], 0);
    chk("ack_sum_held", uo_out[3:0], 0);
    chk("ack_carry_held", uo_out[4], 1);
    step();

    run_op(4'd9, 4'd4, 1'b0, 0, 1'b0, 20, 1'b0);
    run_op(4'd6, 4'd7, 1'b0, 0, 1'b1, 1, 1'b0);
    run_op(4'd10, 4'd11, 1'b0, 3, 1'b0, 1, 1'b0);
    run_op(4'd1, 4'd2, 1'b0, 0, 1'b0, 1, 1'b1);

    // Reset two cycles into ADD aborts without counting.
    ui_in  = {4'd7, 4'd6};
    uio_in = 8'h01;
    step();
    uio_in[0] = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("abort_uo_out", uo_out, 0);
    chk("abort_count", uio_out, 0);
    step();
    rst_n = 1'b1;
    model_count = 0;
    step();
    chk("abort_no_busy", uo_out[5], 0);
    run_op(4'd2, 4'd2, 1'b0, 0, 1'b0, 1, 1'b0);

    run_op(4'd3, 4'd5, 1'b1, 0, 1'b0, 1, 1'b0);
    run_op(4'd5, 4'd3, 1'b1, 0, 1'b0, 1, 1'b0);
    run_op(4'd7, 4'd7, 1'b1, 0, 1'b0, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0,
             1'($urandom), 1, 1'($urandom));
    end

    repeat (10) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
